regfile_mp_clr: RTL and testbench

//  Parametrised multi-read-port register file for the MIPS datapath with optional hardwired-zero

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 29 ++
 rtl/regfile_mp_clr.sv | 102 ++++++++++
 tb/tb_regfile_mp_clr.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the multi-port clearing register file.
package regfile_pkg;

    // Default widths shared with the MIPS datapath
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // CLEAR is the all-zero encoding so that reset lands there directly
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One asynchronous read port: clear mask, hardwired zero, write bypass, array word.
module regfile_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clearing,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_word,
    output logic [DATA_W-1:0] rdata
);

    // Priority: sweep mask, then zero register, then bypass, then stored value
    always_comb begin
        rdata = mem_word;
        if (clearing) begin
            rdata = '0;
        end else if ((ZERO_REG != 0) && (raddr == '0)) begin
            rdata = '0;
        end else if ((BYPASS != 0) && we && (waddr == raddr)) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/regfile_mp_clr.sv
// Multi-read-port register file with hardware clear sweep after reset or on request.
module regfile_mp_clr
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              wr_ok;

    assign busy  = (state_q == ST_CLEAR);
    // Writes to entry 0 are discarded when it is the hardwired zero register
    assign wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

    // State and sweep pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next state: sweep every entry once, then run until a clear is requested
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == LAST) begin
                    state_d   = ST_RUN;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Storage: the sweep owns the write port while clearing; user writes are dropped
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Independent read ports
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[i*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd (
            .clearing (busy),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .raddr    (ra),
            .mem_word (mem[ra]),
            .rdata    (rdata[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp_clr.sv
// Self-checking bench: three configurations against an array-based reference model.
module tb_regfile_mp_clr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // A: default config (ZERO_REG=1, BYPASS=1)
    logic        clr_a, we_a, busy_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;
    // B: ZERO_REG=0
    logic        clr_b, we_b, busy_b;
    logic [4:0]  waddr_b;
    logic [31:0] wdata_b;
    logic [9:0]  raddr_b;
    logic [63:0] rdata_b;
    // C: NUM_RD=4, ADDR_W=3, DATA_W=16, BYPASS=0
    logic        clr_c, we_c, busy_c;
    logic [2:0]  waddr_c;
    logic [15:0] wdata_c;
    logic [11:0] raddr_c;
    logic [63:0] rdata_c;

    regfile_mp_clr dut_a (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_a), .we(we_a), .waddr(waddr_a),
        .wdata(wdata_a), .raddr(raddr_a), .rdata(rdata_a), .busy(busy_a));

    regfile_mp_clr #(.ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_b), .we(we_b), .waddr(waddr_b),
        .wdata(wdata_b), .raddr(raddr_b), .rdata(rdata_b), .busy(busy_b));

    regfile_mp_clr #(.NUM_RD(4), .ADDR_W(3), .DATA_W(16), .BYPASS(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_c), .we(we_c), .waddr(waddr_c),
        .wdata(wdata_c), .raddr(raddr_c), .rdata(rdata_c), .busy(busy_c));

    // Reference contents
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic [15:0] mc [8];

    int n_cmp = 0;
    int n_err = 0;

    task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 32; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        for (int i = 0; i < 8; i++) mc[i] = '0;
    endtask

    // Reset for 2 clocks, sweep lasts 32 cycles, writes during sweep are lost
    task automatic test_reset_sweep();
        int cnt;
        logic [4:0] r0, r1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        cmp32("reset_busy_a", {31'd0, busy_a}, 32'd1);
        cmp32("reset_busy_c", {31'd0, busy_c}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEAD;
        #1;
        cnt = 0;
        while (busy_a && cnt < 200) begin
            cnt++;
            r0 = 5'($urandom); r1 = 5'($urandom);
            raddr_a = {r1, r0};
            #1;
            if (rdata_a !== 64'd0) begin
                n_err++;
                $display("FAIL sweep_rdata: got %h expected 0", rdata_a);
            end
            n_cmp++;
            @(negedge clk); #1;
        end
        we_a = 1'b0;
        cmp32("reset_busy_len", cnt, 32);
        clear_models();
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            raddr_a = {5'(31 - r), 5'(r)};
            #1;
            cmp32("post_sweep_p0", rdata_a[31:0], ma[r]);
            cmp32("post_sweep_p1", rdata_a[63:32], ma[31 - r]);
        end
    endtask

    // Same-cycle bypass and committed value on both ports
    task automatic test_bypass();
        @(negedge clk);
        we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h1234_5678;
        raddr_a = {5'd3, 5'd7};
        #1;
        cmp32("bypass_p0", rdata_a[31:0], 32'h1234_5678);
        cmp32("bypass_other_p1", rdata_a[63:32], ma[3]);
        ma[7] = 32'h1234_5678;
        @(negedge clk);
        we_a = 1'b0; raddr_a = {5'd7, 5'd7};
        #1;
        cmp32("commit_p0", rdata_a[31:0], ma[7]);
        cmp32("commit_p1", rdata_a[63:32], ma[7]);
    endtask

    // Hardwired zero register vs ordinary entry 0
    task automatic test_zero_reg();
        @(negedge clk);
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF; raddr_a = '0;
        we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hFFFF_FFFF; raddr_b = '0;
        #1;
        cmp32("zero_same_p0", rdata_a[31:0], 32'd0);
        cmp32("zero_same_p1", rdata_a[63:32], 32'd0);
        cmp32("nozero_bypass", rdata_b[31:0], 32'hFFFF_FFFF);
        mb[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0;
        #1;
        cmp32("zero_next_p0", rdata_a[31:0], 32'd0);
        cmp32("zero_next_p1", rdata_a[63:32], 32'd0);
        cmp32("nozero_next_p0", rdata_b[31:0], mb[0]);
        cmp32("nozero_next_p1", rdata_b[63:32], mb[0]);
    endtask

    // Fill, request a clear, second request mid-sweep must not extend it
    task automatic test_clear_req();
        int cnt;
        logic [4:0] r0, r1;
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            we_a = 1'b1; waddr_a = 5'(r); wdata_a = 32'(r);
            ma[r] = 32'(r);
        end
        @(negedge clk);
        we_a = 1'b0; raddr_a = {5'd31, 5'd17};
        #1;
        cmp32("fill_p0", rdata_a[31:0], ma[17]);
        cmp32("fill_p1", rdata_a[63:32], ma[31]);
        // request together with a write that the sweep will overwrite
        @(negedge clk);
        clr_a = 1'b1; we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'hABCD;
        #1;
        cmp32("clr_req_busy_low", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        clr_a = 1'b0; we_a = 1'b0;
        #1;
        cnt = 0;
        while (busy_a && cnt < 200) begin
            cnt++;
            clr_a = (cnt == 10);
            r0 = 5'($urandom); r1 = 5'($urandom);
            raddr_a = {r1, r0};
            #1;
            if (rdata_a !== 64'd0) begin
                n_err++;
                $display("FAIL clr_rdata: got %h expected 0", rdata_a);
            end
            n_cmp++;
            @(negedge clk); #1;
        end
        clr_a = 1'b0;
        cmp32("clr_busy_len", cnt, 32);
        for (int i = 0; i < 32; i++) ma[i] = '0;
        for (int r = 0; r < 32; r += 3) begin
            @(negedge clk);
            raddr_a = {5'(31 - r), 5'(r)};
            #1;
            cmp32("clr_after_p0", rdata_a[31:0], ma[r]);
            cmp32("clr_after_p1", rdata_a[63:32], ma[31 - r]);
        end
    endtask

    // Reset at sweep cycle 15 restarts the full sweep
    task automatic test_reset_mid_sweep();
        int cnt;
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        repeat (14) @(negedge clk);
        #1;
        cmp32("mid_busy_before_rst", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cnt = 0;
        while (busy_a && cnt < 200) begin
            cnt++;
            @(negedge clk); #1;
        end
        cmp32("mid_rst_busy_len", cnt, 32);
    endtask

    // Small config: 8-cycle sweep, then random traffic without bypass
    task automatic test_random_small();
        int cnt;
        logic [2:0]  a [4];
        logic [15:0] exp;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cnt = 0;
        while (busy_c && cnt < 200) begin
            cnt++;
            @(negedge clk); #1;
        end
        cmp32("c_busy_len", cnt, 8);
        clear_models();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            we_c    = 1'($urandom);
            waddr_c = 3'($urandom);
            wdata_c = 16'($urandom);
            for (int p = 0; p < 4; p++) a[p] = 3'($urandom);
            if ($urandom_range(0, 3) == 0) a[0] = waddr_c;
            raddr_c = {a[3], a[2], a[1], a[0]};
            #1;
            for (int p = 0; p < 4; p++) begin
                exp = (a[p] == 3'd0) ? 16'd0 : mc[a[p]];
                n_cmp++;
                if (rdata_c[p*16 +: 16] !== exp) begin
                    n_err++;
                    $display("FAIL rand_c port%0d addr%0d: got %h expected %h",
                             p, a[p], rdata_c[p*16 +: 16], exp);
                end
            end
            if (we_c && waddr_c != 3'd0) mc[waddr_c] = wdata_c;
        end
        @(negedge clk);
        we_c = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_a = 0; we_a = 0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
        clr_b = 0; we_b = 0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
        clr_c = 0; we_c = 0; waddr_c = '0; wdata_c = '0; raddr_c = '0;
        clear_models();
        test_reset_sweep();
        test_bypass();
        test_zero_reg();
        test_clear_req();
        test_reset_mid_sweep();
        test_random_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
